// File: rtl/board_cell_plotter.sv
// Purpose : renders a ROWS x COLS board bitmap onto a 160x120 3-bit pixel adapter,
//           redrawing only cells that differ from a shadow copy of what is on screen.
// Latency : 1 accept + ROWS*COLS scan cycles + CELL*CELL cycles per redrawn cell + 1 finish cycle.
// Backpressure: none toward the adapter (one pixel per clock); start is ignored while a pass runs.
//
// Ports:
//   CLOCK_50, resetn          - clock, asynchronous active-low reset
//   start                     - one-cycle render request, accepted only when idle
//   full_redraw, clear        - mode qualifiers sampled with start
//   board                     - row r at bits [r*COLS +: COLS], 1 = occupied
//   fg_colour, bg_colour      - occupied / empty colours sampled with start
//   x, y, colour, plot        - pixel stream to the adapter
//   busy, done                - pass in progress / one-cycle completion pulse
module board_cell_plotter #(
    parameter int ROWS = 23,
    parameter int COLS = 10,
    parameter int CELL = 4,
    parameter int X0   = 60,
    parameter int Y0   = 14
) (
    input  logic                   CLOCK_50,
    input  logic                   resetn,
    input  logic                   start,
    input  logic                   full_redraw,
    input  logic                   clear,
    input  logic [ROWS*COLS-1:0]   board,
    input  logic [2:0]             fg_colour,
    input  logic [2:0]             bg_colour,
    output logic [7:0]             x,
    output logic [6:0]             y,
    output logic [2:0]             colour,
    output logic                   plot,
    output logic                   busy,
    output logic                   done
);

    localparam int NCELL = ROWS * COLS;
    localparam int IW    = (NCELL > 1) ? $clog2(NCELL) : 1;
    localparam int RW    = (ROWS  > 1) ? $clog2(ROWS)  : 1;
    localparam int CW    = (COLS  > 1) ? $clog2(COLS)  : 1;
    localparam int PW    = (CELL  > 1) ? $clog2(CELL)  : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_DRAW,
        S_FINISH
    } state_t;

    state_t             state_q, state_d;
    logic [NCELL-1:0]   snap_q, snap_d;
    logic [NCELL-1:0]   shadow_q, shadow_d;
    logic [2:0]         fg_q, fg_d;
    logic [2:0]         bg_q, bg_d;
    logic               full_q, full_d;
    logic               clr_q, clr_d;
    logic               force_full_q, force_full_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic [RW-1:0]      r_q, r_d;
    logic [CW-1:0]      c_q, c_d;
    logic [PW-1:0]      px_q, px_d;
    logic [PW-1:0]      py_q, py_d;
    logic [7:0]         x_q, x_d;
    logic [6:0]         y_q, y_d;
    logic [2:0]         col_q, col_d;

    logic               cell_bit;
    logic               shadow_bit;
    logic               last_cell;
    logic               advance;
    logic [7:0]         x_calc;
    logic [6:0]         y_calc;
    logic [2:0]         draw_colour;

    assign cell_bit    = snap_q[idx_q];
    assign shadow_bit  = shadow_q[idx_q];
    assign last_cell   = (idx_q == IW'(NCELL - 1));

    // Pixel coordinates are truncated to the adapter port widths.
    assign x_calc      = 8'(X0 + int'(c_q) * CELL + int'(px_q));
    assign y_calc      = 7'(Y0 + int'(r_q) * CELL + int'(py_q));
    assign draw_colour = clr_q ? bg_q : (cell_bit ? fg_q : bg_q);

    // Status and pixel outputs decode straight from state so an async reset
    // drops them immediately. x/y/colour show the hold registers outside DRAW.
    assign plot   = (state_q == S_DRAW);
    assign done   = (state_q == S_FINISH);
    assign busy   = (state_q == S_SCAN) || (state_q == S_DRAW);
    assign x      = plot ? x_calc      : x_q;
    assign y      = plot ? y_calc      : y_q;
    assign colour = plot ? draw_colour : col_q;

    always_comb begin
        state_d      = state_q;
        snap_d       = snap_q;
        shadow_d     = shadow_q;
        fg_d         = fg_q;
        bg_d         = bg_q;
        full_d       = full_q;
        clr_d        = clr_q;
        force_full_d = force_full_q;
        idx_d        = idx_q;
        r_d          = r_q;
        c_d          = c_q;
        px_d         = px_q;
        py_d         = py_q;
        x_d          = x_q;
        y_d          = y_q;
        col_d        = col_q;
        advance      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    snap_d  = board;
                    fg_d    = fg_colour;
                    bg_d    = bg_colour;
                    full_d  = full_redraw | clear | force_full_q;
                    clr_d   = clear;
                    idx_d   = '0;
                    r_d     = '0;
                    c_d     = '0;
                    state_d = S_SCAN;
                end
            end

            S_SCAN: begin
                if (full_q || (cell_bit != shadow_bit)) begin
                    px_d    = '0;
                    py_d    = '0;
                    state_d = S_DRAW;
                end else begin
                    advance = 1'b1;
                end
            end

            S_DRAW: begin
                x_d   = x_calc;
                y_d   = y_calc;
                col_d = draw_colour;
                if (px_q == PW'(CELL - 1)) begin
                    px_d = '0;
                    if (py_q == PW'(CELL - 1)) begin
                        // Last pixel of the square: screen now matches this cell.
                        py_d            = '0;
                        shadow_d[idx_q] = clr_q ? 1'b0 : cell_bit;
                        advance         = 1'b1;
                    end else begin
                        py_d = py_q + PW'(1);
                    end
                end else begin
                    px_d = px_q + PW'(1);
                end
            end

            S_FINISH: begin
                force_full_d = 1'b0;
                state_d      = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Row-major step shared by SCAN (clean cell) and DRAW (last pixel).
        if (advance) begin
            if (last_cell) begin
                state_d = S_FINISH;
            end else begin
                state_d = S_SCAN;
                idx_d   = idx_q + IW'(1);
                if (c_q == CW'(COLS - 1)) begin
                    c_d = '0;
                    r_d = r_q + RW'(1);
                end else begin
                    c_d = c_q + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q      <= S_IDLE;
            snap_q       <= '0;
            shadow_q     <= '0;
            fg_q         <= '0;
            bg_q         <= '0;
            full_q       <= 1'b0;
            clr_q        <= 1'b0;
            force_full_q <= 1'b1;
            idx_q        <= '0;
            r_q          <= '0;
            c_q          <= '0;
            px_q         <= '0;
            py_q         <= '0;
            x_q          <= '0;
            y_q          <= '0;
            col_q        <= '0;
        end else begin
            state_q      <= state_d;
            snap_q       <= snap_d;
            shadow_q     <= shadow_d;
            fg_q         <= fg_d;
            bg_q         <= bg_d;
            full_q       <= full_d;
            clr_q        <= clr_d;
            force_full_q <= force_full_d;
            idx_q        <= idx_d;
            r_q          <= r_d;
            c_q          <= c_d;
            px_q         <= px_d;
            py_q         <= py_d;
            x_q          <= x_d;
            y_q          <= y_d;
            col_q        <= col_d;
        end
    end

endmodule

// File: tb/tb_board_cell_plotter.sv
// Purpose : directed self-checking bench for board_cell_plotter at default parameters.
// Latency : checks pass length in cycles counted from the accepting clock.
// Backpressure: none; the bench drives start pulses and observes the pixel stream.
module tb_board_cell_plotter;

    localparam int N = 230;

    logic           clk = 1'b0;
    logic           resetn;
    logic           start;
    logic           full_redraw;
    logic           clear;
    logic [N-1:0]   board;
    logic [2:0]     fg_colour;
    logic [2:0]     bg_colour;
    logic [7:0]     x;
    logic [6:0]     y;
    logic [2:0]     colour;
    logic           plot;
    logic           busy;
    logic           done;

    int             n_cmp = 0;
    int             n_err = 0;

    int             r_cyc, r_plots, r_badcol, r_badgeo, r_busyerr, r_done;
    logic [7:0]     pix_x [16];
    logic [6:0]     pix_y [16];
    logic [7:0]     last_x;
    logic [6:0]     last_y;

    always #5 clk = ~clk;

    board_cell_plotter dut (
        .CLOCK_50    (clk),
        .resetn      (resetn),
        .start       (start),
        .full_redraw (full_redraw),
        .clear       (clear),
        .board       (board),
        .fg_colour   (fg_colour),
        .bg_colour   (bg_colour),
        .x           (x),
        .y           (y),
        .colour      (colour),
        .plot        (plot),
        .busy        (busy),
        .done        (done)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One render pass. Cycle 1 is the accepting cycle; the board input is
    // scrambled after acceptance so only the snapshot can drive the result.
    task automatic run_pass(input logic fr, input logic clr, input logic [N-1:0] brd,
                            input logic [2:0] fg, input logic [2:0] bg,
                            input logic [2:0] exp_col, input int inject);
        r_plots = 0; r_badcol = 0; r_badgeo = 0; r_busyerr = 0; r_done = 0;
        @(negedge clk);
        full_redraw = fr; clear = clr; board = brd;
        fg_colour = fg; bg_colour = bg; start = 1'b1;
        r_cyc = 1;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            r_cyc++;
            if (plot) begin
                if (r_plots < 16) begin
                    pix_x[r_plots] = x;
                    pix_y[r_plots] = y;
                end
                last_x = x;
                last_y = y;
                r_plots++;
                if (colour !== exp_col) r_badcol++;
                if (x < 8'd60 || x > 8'd99 || y < 7'd14 || y > 7'd105) r_badgeo++;
            end
            start = (r_cyc == inject);
            if (r_cyc == 2) board = ~brd;
            if (done) begin
                r_done = 1;
                break;
            end
            if (!busy) r_busyerr++;
        end
        start = 1'b0;
        board = brd;
        chk("pass_done_seen", r_done, 1);
    endtask

    initial begin
        logic [N-1:0] brd;
        logic [N-1:0] all1;
        all1 = '1;

        resetn = 1'b0; start = 1'b0; full_redraw = 1'b0; clear = 1'b0;
        board = '0; fg_colour = 3'b010; bg_colour = 3'b000;
        #12;
        chk("rst_x", x, 0);
        chk("rst_y", y, 0);
        chk("rst_colour", colour, 0);
        chk("rst_plot", plot, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        @(negedge clk);
        resetn = 1'b1;

        // Forced full pass after reset on an empty board.
        run_pass(1'b0, 1'b0, '0, 3'b010, 3'b000, 3'b000, 0);
        chk("p1_cycles", r_cyc, 3912);
        chk("p1_plots", r_plots, 3680);
        chk("p1_badcol", r_badcol, 0);
        chk("p1_badgeo", r_badgeo, 0);
        chk("p1_busy", r_busyerr, 0);
        chk("p1_first_x", pix_x[0], 60);
        chk("p1_first_y", pix_y[0], 14);
        chk("p1_last_x", last_x, 99);
        chk("p1_last_y", last_y, 105);

        // Nothing changed: scan only.
        run_pass(1'b0, 1'b0, '0, 3'b010, 3'b000, 3'b000, 0);
        chk("p2_cycles", r_cyc, 232);
        chk("p2_plots", r_plots, 0);

        // Row 5, column 3 set.
        brd = '0;
        brd[53] = 1'b1;
        run_pass(1'b0, 1'b0, brd, 3'b010, 3'b000, 3'b010, 0);
        chk("p3_cycles", r_cyc, 248);
        chk("p3_plots", r_plots, 16);
        chk("p3_badcol", r_badcol, 0);
        for (int i = 0; i < 16; i++) begin
            chk("p3_px_x", pix_x[i], 72 + (i % 4));
            chk("p3_px_y", pix_y[i], 34 + (i / 4));
        end

        // Same cell cleared again: redrawn in background colour.
        run_pass(1'b0, 1'b0, '0, 3'b010, 3'b000, 3'b000, 0);
        chk("p4_cycles", r_cyc, 248);
        chk("p4_plots", r_plots, 16);
        chk("p4_badcol", r_badcol, 0);
        for (int i = 0; i < 16; i++) begin
            chk("p4_px_x", pix_x[i], 72 + (i % 4));
            chk("p4_px_y", pix_y[i], 34 + (i / 4));
        end

        run_pass(1'b0, 1'b0, '0, 3'b010, 3'b000, 3'b000, 0);
        chk("p5_cycles", r_cyc, 232);
        chk("p5_plots", r_plots, 0);

        // start coinciding with done must be ignored.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("done_start_busy", busy, 0);
        chk("done_start_done", done, 0);
        @(negedge clk);
        chk("done_start_busy2", busy, 0);
        chk("done_start_plot", plot, 0);

        // Clear on a full board: every cell in background colour.
        run_pass(1'b0, 1'b1, all1, 3'b010, 3'b101, 3'b101, 0);
        chk("p6_cycles", r_cyc, 3912);
        chk("p6_plots", r_plots, 3680);
        chk("p6_badcol", r_badcol, 0);

        // Shadow is zero after clear, so an all-1 board redraws everything.
        run_pass(1'b0, 1'b0, all1, 3'b010, 3'b101, 3'b010, 0);
        chk("p7_cycles", r_cyc, 3912);
        chk("p7_plots", r_plots, 3680);
        chk("p7_badcol", r_badcol, 0);

        // Explicit full redraw of an unchanged board.
        run_pass(1'b1, 1'b0, all1, 3'b010, 3'b101, 3'b010, 0);
        chk("p8_cycles", r_cyc, 3912);
        chk("p8_plots", r_plots, 3680);

        // Reset while drawing the first cell.
        @(negedge clk);
        board = all1; full_redraw = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0; full_redraw = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (plot) break;
            @(negedge clk);
        end
        chk("md_plot_seen", plot, 1);
        #2;
        resetn = 1'b0;
        #1;
        chk("md_plot", plot, 0);
        chk("md_busy", busy, 0);
        chk("md_done", done, 0);
        chk("md_x", x, 0);
        chk("md_y", y, 0);
        @(negedge clk);
        resetn = 1'b1;

        // Post-reset pass is full even with an unchanged empty board; a start
        // pulse mid-pass must not lengthen it.
        run_pass(1'b0, 1'b0, '0, 3'b010, 3'b011, 3'b011, 100);
        chk("p9_cycles", r_cyc, 3912);
        chk("p9_plots", r_plots, 3680);
        chk("p9_badcol", r_badcol, 0);
        chk("p9_busy", r_busyerr, 0);

        run_pass(1'b0, 1'b0, '0, 3'b010, 3'b011, 3'b011, 0);
        chk("p10_cycles", r_cyc, 232);
        chk("p10_plots", r_plots, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
